multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core. Sequences the shared datapath: PC, IR, ALU, ImmExt, regfile, memory.
//  Decodes op/funct3 and emits per-state strobes and mux selects. Drives ImmExt.ImmSrc; ImmExt selects U-type from instr[4].
//  Also provides a retired-instruction counter and a sticky illegal-opcode flag.
// PARAMETERS
//  INSTRET_W        32  width of instret counter, wraps modulo 2^INSTRET_W
//  TRAP_ON_ILLEGAL  1   1: illegal op parks FSM in S_TRAP; 0: illegal op flagged, then back to S_FETCH
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          async active-low reset
//  op         in   7          instr[6:0] from IR
//  funct3     in   3          instr[14:12]
//  zero       in   1          ALU zero flag
//  pc_write   out  1          PC load enable = pc_update | (branch & (zero ^ funct3[0]))
//  adr_src    out  1          0: memory address = PC; 1: memory address = ALUOut
//  mem_write  out  1          data memory write strobe
//  ir_write   out  1          IR/OldPC load enable
//  result_src out  2          00 ALUOut, 01 ReadData, 10 ALUResult
//  alu_src_a  out  2          00 PC, 01 OldPC, 10 rs1, 11 zero
//  alu_src_b  out  2          00 rs2, 01 ImmExt, 10 const 4
//  alu_op     out  2          00 add, 01 sub/compare, 10 funct decode
//  imm_src    out  2          00 I, 01 S/U, 10 B, 11 J
//  reg_write  out  1          regfile write enable
//  illegal    out  1          sticky; set on undecodable op/funct3 in S_DECODE
//  instret    out  INSTRET_W  count of completed instructions
// BEHAVIOUR
//  - Outputs are Moore-decoded from the state register. Exceptions: imm_src decodes from op in every state; pc_write also uses zero and funct3.
//  - Reset: async clear to S_RST. illegal=0, instret=0. All strobes 0 while rst_n is low and in S_RST. Selects 00 unless listed.
//  - imm_src decode: lw/I-ALU/R 00, sw 01, lui 01, beq/bne 10, jal 11, any other op 00.
//  - States (non-zero outputs -> next state):
//    S_RST: none -> S_FETCH
//    S_FETCH: ir_write, src_b=10, res=10, pc_update -> S_DECODE
//    S_DECODE: src_a=01, src_b=01 (branch/jal target precompute) -> by op:
//      0000011 lw/0100011 sw -> S_MEMADR; 0110011 -> S_EXECR; 0010011 -> S_EXECI;
//      0110111 lui -> S_LUI; 1101111 -> S_JAL; 1100011 with funct3 000/001 -> S_BRANCH; else -> S_TRAP
//    S_MEMADR: src_a=10, src_b=01 -> lw: S_MEMREAD, sw: S_MEMWRITE
//    S_MEMREAD: adr_src -> S_MEMWB
//    S_MEMWB: res=01, reg_write -> S_FETCH
//    S_MEMWRITE: adr_src, mem_write -> S_FETCH
//    S_EXECR: src_a=10, src_b=00, alu_op=10 -> S_ALUWB
//    S_EXECI: src_a=10, src_b=01, alu_op=10 -> S_ALUWB
//    S_LUI: src_a=11, src_b=01 -> S_ALUWB
//    S_JAL: src_a=01, src_b=10, pc_update -> S_ALUWB
//    S_ALUWB: reg_write -> S_FETCH
//    S_BRANCH: src_a=10, src_b=00, alu_op=01, branch -> S_FETCH
//    S_TRAP: all strobes 0. Sets illegal. TRAP_ON_ILLEGAL=1: stay until reset; 0: -> S_FETCH
//  - Latency in cycles incl. fetch: lw 5; sw, R, I, lui, jal 4; branch 3.
//  - instret increments by 1 on every transition into S_FETCH, except from S_RST or S_TRAP. Wraps all-ones -> 0.
//  - Reset mid-instruction: strobes drop asynchronously; no partial write completes after rst_n falls.
// CONFIGURATION
//  MC_MEM_READY_EN defined:
//    - Adds input port mem_ready (1 bit).
//    - S_FETCH, S_MEMREAD and S_MEMWRITE hold state while mem_ready=0.
//    - In S_FETCH, ir_write and pc_update are gated by mem_ready. mem_write stays high throughout S_MEMWRITE.
//  MC_MEM_READY_EN undefined: no mem_ready port; behaves as mem_ready=1 (fixed latencies above).
// TESTING
//  1. Release reset, op=0010011 (addi x1,x2,-7 = 0xFF910093) -> RST,FETCH,DECODE,EXECI,ALUWB; reg_write 1 cycle; instret 0->1.
//  2. lw (0x00012083) -> 5 cycles, res=01 in MEMWB. sw (0x00312023) -> imm_src=01, mem_write high 1 cycle, adr_src=1.
//  3. beq (funct3=000), zero=1 -> pc_write high in FETCH and BRANCH. bne (funct3=001), zero=1 -> pc_write only in FETCH.
//  4. jal (0x010000EF) -> imm_src=11, pc_write in S_JAL, reg_write next cycle. lui -> imm_src=01, src_a=11.
//  5. op=1111111 (0x0000007F), TRAP_ON_ILLEGAL=1 -> illegal=1, strobes 0 and instret frozen for 20 cycles. rst_n pulse -> clears.
//  6. rst_n low mid-S_MEMWRITE -> mem_write 0 before next edge, instret=0, S_RST. With MC_MEM_READY_EN: mem_ready=0 for 3 FETCH cycles -> ir_write, pc_write 0 until ready.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences PC, IR, ALU, ImmExt, regfile and memory.
// Optional `define MC_MEM_READY_EN adds a mem_ready handshake that stretches fetch and data accesses.
module multicycle_ctrl_fsm #(
  parameter int unsigned INSTRET_W       = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 zero,
`ifdef MC_MEM_READY_EN
  input  logic                 mem_ready,
`endif
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           imm_src,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_LUI, S_JAL, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for each state; anything not listed stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t                 r_state;
  ctrl_t                  r_ctrl;
  logic                   r_illegal;
  logic [INSTRET_W-1:0]   r_instret;
  state_t                 w_next;
  logic                   w_retire;
  logic                   w_ready;
  logic                   w_fetch_go;

`ifdef MC_MEM_READY_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next = r_state;
    case (r_state)
      S_RST:      w_next = S_FETCH;
      S_FETCH:    if (w_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_LUI:       w_next = S_LUI;
          OP_JAL:       w_next = S_JAL;
          OP_BR:        w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
      S_MEMWRITE: if (w_ready) w_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH:       w_next = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_JAL:   w_next = S_ALUWB;
      S_TRAP:     w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      default:    w_next = S_RST;
    endcase
  end

  // An instruction retires when its last state hands back to fetch; reset and trap exits do not count.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                    (r_state != S_RST) && (r_state != S_TRAP);

  // NOTE: sequential state uses non-blocking assignments only; the control word is registered
  // against the next state, so outputs are glitch-free and drop the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
      if (r_state == S_DECODE && w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  // Fetch-side strobes wait for memory; pc_update in S_JAL is never gated.
  assign w_fetch_go = (r_state != S_FETCH) || w_ready;

  assign ir_write   = r_ctrl.ir_write & w_ready;
  assign pc_write   = (r_ctrl.pc_update & w_fetch_go) | (r_ctrl.branch & (zero ^ funct3[0]));
  assign adr_src    = r_ctrl.adr_src;
  assign mem_write  = r_ctrl.mem_write;
  assign reg_write  = r_ctrl.reg_write;
  assign result_src = r_ctrl.result_src;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign alu_op     = r_ctrl.alu_op;
  assign illegal    = r_illegal;
  assign instret    = r_instret;

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW, OP_LUI: imm_src = 2'b01;
      OP_BR:         imm_src = 2'b10;
      OP_JAL:        imm_src = 2'b11;
      default:       imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-instruction cycle plans from a behavioural model,
// one compare process on every negedge, plus literal pins on latency, wrap, trap and reset.
module tb_multicycle_ctrl_fsm;

  localparam int IW          = 4;
  localparam int TRAP_CYCLES = 20;
  localparam int N_RANDOM    = 300;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [6:0]    op     = 7'b0;
  logic [2:0]    funct3 = 3'b0;
  logic          zero   = 1'b0;
`ifdef MC_MEM_READY_EN
  logic          mem_ready = 1'b1;
`endif
  logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [IW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.INSTRET_W(IW), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
`ifdef MC_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [IW-1:0] instret;
  } vec_t;

  typedef enum {K_LW, K_SW, K_R, K_I, K_LUI, K_JAL, K_BR, K_ILL} kind_t;

  vec_t w_act;
  assign w_act = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal,
                  result_src, alu_src_a, alu_src_b, alu_op, imm_src, instret};

  int   vectors     = 0;
  int   miscompares = 0;
  int   m_instret   = 0;
  bit   m_illegal   = 1'b0;
  vec_t exp_cur;
  bit   exp_valid   = 1'b0;
  int   exp_step    = -1;
  vec_t plan[$];

  function automatic kind_t classify(input logic [6:0] o, input logic [2:0] f);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0110111: return K_LUI;
      7'b1101111: return K_JAL;
      7'b1100011: return (f == 3'b000 || f == 3'b001) ? K_BR : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011, 7'b0110111: return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic vec_t base(input logic [6:0] o);
    vec_t v;
    v         = '0;
    v.imm_src = imm_of(o);
    v.illegal = m_illegal;
    v.instret = IW'(m_instret % (1 << IW));
    return v;
  endfunction

  // Cycle-by-cycle expectation of one instruction, starting with its fetch cycle.
  task automatic plan_instr(input logic [6:0] o, input logic [2:0] f, input logic z);
    vec_t  v;
    kind_t k;
    k = classify(o, f);
    plan.delete();
    v = base(o); v.ir_write = 1; v.pc_write = 1; v.alu_src_b = 2'b10; v.result_src = 2'b10;
    plan.push_back(v);
    v = base(o); v.alu_src_a = 2'b01; v.alu_src_b = 2'b01;
    plan.push_back(v);
    case (k)
      K_LW, K_SW: begin
        v = base(o); v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; plan.push_back(v);
        if (k == K_LW) begin
          v = base(o); v.adr_src = 1; plan.push_back(v);
          v = base(o); v.result_src = 2'b01; v.reg_write = 1; plan.push_back(v);
        end else begin
          v = base(o); v.adr_src = 1; v.mem_write = 1; plan.push_back(v);
        end
      end
      K_R, K_I, K_LUI, K_JAL: begin
        v = base(o);
        if (k == K_R)   begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b00; v.alu_op = 2'b10; end
        if (k == K_I)   begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; v.alu_op = 2'b10; end
        if (k == K_LUI) begin v.alu_src_a = 2'b11; v.alu_src_b = 2'b01; end
        if (k == K_JAL) begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.pc_write = 1; end
        plan.push_back(v);
        v = base(o); v.reg_write = 1; plan.push_back(v);
      end
      K_BR: begin
        v = base(o); v.alu_src_a = 2'b10; v.alu_op = 2'b01; v.pc_write = z ^ f[0];
        plan.push_back(v);
      end
      default: begin
        m_illegal = 1'b1;
        repeat (TRAP_CYCLES) begin
          v = base(o);
          plan.push_back(v);
        end
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one instruction; returns at posedge+1 of its last planned cycle.
  task automatic run_instr(input logic [31:0] instr, input logic z);
    logic [6:0] o;
    logic [2:0] f;
    o = instr[6:0];
    f = instr[14:12];
    plan_instr(o, f, z);
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        op = o; funct3 = f; zero = z;
`ifdef MC_MEM_READY_EN
        mem_ready = 1'b1;
`endif
      end
      exp_cur = plan[i]; exp_step = i; exp_valid = 1'b1;
    end
    if (classify(o, f) != K_ILL) m_instret++;
  endtask

  task automatic apply_reset(input bit wait_edge);
    if (wait_edge) begin
      @(negedge clk); #2;
    end else begin
      #1;
    end
    exp_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_strobes", {27'b0, pc_write, adr_src, mem_write, ir_write, reg_write}, 32'h0);
    check("rst_instret", 32'(instret), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_instret = 0;
    m_illegal = 1'b0;
    exp_cur   = base(op);
    exp_step  = -1;
    exp_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if (w_act !== exp_cur) begin
        miscompares++;
        $display("FAIL cycle_vec op=%b f3=%b step=%0d: got %h expected %h",
                 op, funct3, exp_step, w_act, exp_cur);
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [6:0]  ro;
    logic [2:0]  rf;
    int          pick;

    apply_reset(1'b1);

    run_instr(32'hFF910093, 1'b0);                 // addi x1,x2,-7
    check("lat_addi", plan.size(), 4);
    @(negedge clk);
    check("addi_reg_write", 32'(reg_write), 32'h1);
    check("addi_instret_pre", 32'(instret), 32'h0);

    run_instr(32'h00012083, 1'b0);                 // lw
    check("lat_lw", plan.size(), 5);
    @(negedge clk);
    check("lw_result_src", 32'(result_src), 32'h1);
    check("lw_instret", 32'(instret), 32'h1);

    run_instr(32'h00312023, 1'b0);                 // sw
    check("lat_sw", plan.size(), 4);
    @(negedge clk);
    check("sw_mem_write", {30'b0, mem_write, adr_src}, 32'h3);
    check("sw_imm_src", 32'(imm_src), 32'h1);

    run_instr(32'h00000063, 1'b1);                 // beq, zero=1: taken
    check("lat_beq", plan.size(), 3);
    @(negedge clk);
    check("beq_pc_write", 32'(pc_write), 32'h1);

    run_instr(32'h00001063, 1'b1);                 // bne, zero=1: not taken
    @(negedge clk);
    check("bne_pc_write", 32'(pc_write), 32'h0);

    run_instr(32'h010000EF, 1'b0);                 // jal
    @(negedge clk);
    check("jal_wb", {29'b0, reg_write, imm_src}, 32'h7);

    run_instr(32'h000000B7, 1'b0);                 // lui
    check("lat_lui", plan.size(), 4);

    repeat (12) run_instr(32'hFF910093, 1'b0);     // 18 retired at the last ALUWB -> 18 mod 16
    @(negedge clk);
    check("instret_wrap", 32'(instret), 32'h2);

`ifdef MC_MEM_READY_EN
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      exp_valid = 1'b0; mem_ready = 1'b0; op = 7'b0010011;
      @(negedge clk);
      check("stall_ir_write", 32'(ir_write), 32'h0);
      check("stall_pc_write", 32'(pc_write), 32'h0);
    end
    run_instr(32'hFF910093, 1'b0);
`endif

    // Reset while the store strobe is up.
    plan_instr(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin op = 7'b0100011; funct3 = 3'b010; zero = 1'b0; end
      exp_cur = plan[i]; exp_step = i; exp_valid = 1'b1;
    end
    @(negedge clk); #1;
    check("sw_mw_before_rst", 32'(mem_write), 32'h1);
    apply_reset(1'b0);

    run_instr(32'hFF910093, 1'b0);
    run_instr(32'h0000007F, 1'b0);                 // illegal op parks in trap
    @(negedge clk);
    check("trap_illegal", 32'(illegal), 32'h1);
    check("trap_instret", 32'(instret), 32'h1);
    apply_reset(1'b1);

    for (int n = 0; n < N_RANDOM; n++) begin
      pick = $urandom_range(0, 19);
      rf   = 3'($urandom);
      case (pick)
        0, 1, 2: ro = 7'b0000011;
        3, 4:    ro = 7'b0100011;
        5, 6, 7: ro = 7'b0110011;
        8, 9, 10: ro = 7'b0010011;
        11:      ro = 7'b0110111;
        12, 13:  ro = 7'b1101111;
        14, 15, 16: begin ro = 7'b1100011; rf = 3'($urandom_range(0, 1)); end
        17:      begin ro = 7'b1100011; rf = 3'($urandom_range(2, 7)); end
        default: begin
          do ro = 7'($urandom); while (classify(ro, 3'b000) != K_ILL);
        end
      endcase
      w = 32'($urandom);
      w[6:0]   = ro;
      w[14:12] = rf;
      run_instr(w, 1'($urandom));
      if (classify(ro, rf) == K_ILL) apply_reset(1'b1);
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
